// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(16,11) SECDED encoder and its sequencer.
package hamming_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam int NUM_MSG_DEF  = 15;
    localparam int SRC_BASE_DEF = 0;
    localparam int DST_BASE_DEF = 30;

    // Code-word layout: parity bits sit at power-of-two positions, p0 is overall parity.
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int D1_POS = 3;
    localparam int P4_POS = 4;
    localparam int D2_POS = 5;
    localparam int P8_POS = 8;
    localparam int D5_POS = 9;

endpackage

// File: rtl/hamming_enc.sv
// Combinational Hamming(16,11) encoder with overall parity bit (SECDED).
module hamming_enc
    import hamming_pkg::*;
(
    input  logic [11:1] d,
    output logic [15:0] code
);

    logic p8, p4, p2, p1, p0;

    always_comb begin
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;

        code                = '0;
        code[D5_POS +: 7]   = d[11:5];
        code[P8_POS]        = p8;
        code[D2_POS +: 3]   = d[4:2];
        code[P4_POS]        = p4;
        code[D1_POS]        = d[1];
        code[P2_POS]        = p2;
        code[P1_POS]        = p1;
        code[P0_POS]        = p0;
    end

endmodule

// File: rtl/hamming_enc_seq.sv
// Reads NUM_MSG two-byte messages from data memory, Hamming-encodes each and
// writes the 16-bit code words back, four cycles per message.
module hamming_enc_seq
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = NUM_MSG_DEF,
    parameter int SRC_BASE = SRC_BASE_DEF,
    parameter int DST_BASE = DST_BASE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] mem_rd_data,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
    localparam logic [7:0] DST_B    = 8'(DST_BASE);
    localparam logic [7:0] LAST_IDX = 8'(NUM_MSG - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [11:1] data_q, data_d;
    logic [15:0] code;
    logic [7:0]  two_i;

    assign two_i = idx_q + idx_q;

    hamming_enc u_enc (
        .d    (data_q),
        .code (code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d = RD_LO;
                    idx_d   = '0;
                end
            end
            RD_LO: begin
                busy        = 1'b1;
                mem_addr    = SRC_B + two_i;
                data_d[8:1] = mem_rd_data;
                state_d     = RD_HI;
            end
            RD_HI: begin
                // Only the low three bits of the high byte carry message data.
                busy         = 1'b1;
                mem_addr     = SRC_B + two_i + 8'd1;
                data_d[11:9] = mem_rd_data[2:0];
                state_d      = WR_LO;
            end
            WR_LO: begin
                busy        = 1'b1;
                mem_addr    = DST_B + two_i;
                mem_wr_en   = 1'b1;
                mem_wr_data = code[7:0];
                state_d     = WR_HI;
            end
            WR_HI: begin
                busy        = 1'b1;
                mem_addr    = DST_B + two_i + 8'd1;
                mem_wr_en   = 1'b1;
                mem_wr_data = code[15:8];
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD_LO;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Bench for hamming_enc_seq: byte-wide memory model, write scoreboard and vector table.
module tb_hamming_enc_seq;

    localparam int NMSG = 15;
    localparam int SRC  = 0;
    localparam int DST  = 30;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] mem_rd_data, mem_addr, mem_wr_data;
    logic       mem_wr_en, busy, done;

    logic [7:0] mem      [0:255];
    logic [7:0] src_copy [0:255];
    logic [7:0] exp_dst  [0:255];

    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    wr_t sb_q[$];

    typedef struct { logic [7:0] hi; logic [7:0] lo; logic [7:0] e30; logic [7:0] e31; } vec_t;
    vec_t vt [5];

    int total, bad;
    logic s_busy, s_done, s_we;
    logic [7:0] s_addr, s_wd;

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    hamming_enc_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_rd_data (mem_rd_data),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoder: classic Hamming positions, parity p covers every position k with k&p.
    function automatic logic [15:0] ref_enc(input logic [10:0] dv);
        logic [15:0] c;
        int j;
        c = '0;
        j = 0;
        for (int k = 3; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k] = dv[j];
                j++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            for (int k = 1; k < 16; k++) begin
                if (k != p && (k & p) != 0) c[p] = c[p] ^ c[k];
            end
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    // One clock: sample outputs at negedge, score any write, apply it to memory after posedge.
    task automatic cyc();
        logic pend;
        logic [7:0] pa, pd;
        wr_t e;
        pend = 1'b0;
        pa = '0;
        pd = '0;
        @(negedge clk);
        s_busy = busy; s_done = done; s_we = mem_wr_en; s_addr = mem_addr; s_wd = mem_wr_data;
        if (mem_wr_en) begin
            pend = 1'b1;
            pa = mem_addr;
            pd = mem_wr_data;
            if (sb_q.size() == 0) begin
                chk("unexpected_write_addr", int'(pa), 256);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", int'(pa), int'(e.addr));
                chk("wr_data", int'(pd), int'(e.data));
            end
        end
        @(posedge clk);
        #1;
        if (pend) mem[pa] = pd;
    endtask

    task automatic fill();
        for (int k = 0; k < 256; k++) mem[k] = (k < DST) ? 8'($urandom) : 8'hA5;
    endtask

    task automatic push_run();
        logic [10:0] dv;
        logic [15:0] c;
        sb_q.delete();
        for (int k = 0; k < DST; k++) src_copy[k] = mem[k];
        for (int i = 0; i < NMSG; i++) begin
            dv = {mem[SRC + 2*i + 1][2:0], mem[SRC + 2*i]};
            c  = ref_enc(dv);
            exp_dst[DST + 2*i]     = c[7:0];
            exp_dst[DST + 2*i + 1] = c[15:8];
            sb_q.push_back('{8'(DST + 2*i), c[7:0]});
            sb_q.push_back('{8'(DST + 2*i + 1), c[15:8]});
        end
    endtask

    task automatic run(input int pulse_at, input int hold);
        int bc;
        bit fin;
        push_run();
        start = 1'b1;
        cyc();
        start = 1'b0;
        bc = 0;
        fin = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            if (n == pulse_at || n < hold) start = 1'b1;
            cyc();
            start = 1'b0;
            if (n == 1) begin
                chk("first_cycle_busy", int'(s_busy), 1);
                chk("first_cycle_done", int'(s_done), 0);
            end
            if (s_busy) bc++;
            if (s_done) begin
                fin = 1'b1;
                break;
            end
        end
        chk("run_finished", int'(fin), 1);
        chk("busy_cycles", bc, 4 * NMSG);
        chk("done_addr", int'(s_addr), 0);
        chk("done_wdata", int'(s_wd), 0);
        chk("done_we", int'(s_we), 0);
        chk("sb_left", sb_q.size(), 0);
        for (int k = 0; k < 2 * NMSG; k++) chk("dst_byte", int'(mem[DST + k]), int'(exp_dst[DST + k]));
        for (int k = 0; k < DST; k++) chk("src_byte", int'(mem[k]), int'(src_copy[k]));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        vt[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vt[1] = '{8'h07, 8'hFF, 8'hFF, 8'hFF};
        vt[2] = '{8'h00, 8'h01, 8'h0F, 8'h00};
        vt[3] = '{8'h04, 8'h00, 8'h17, 8'h81};
        vt[4] = '{8'hF8, 8'h00, 8'h00, 8'h00};
        fill();
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_busy", int'(s_busy), 0);
        chk("rst_done", int'(s_done), 0);
        chk("rst_we", int'(s_we), 0);
        chk("rst_addr", int'(s_addr), 0);
        chk("rst_wdata", int'(s_wd), 0);

        for (int v = 0; v < 5; v++) begin
            fill();
            mem[SRC]     = vt[v].lo;
            mem[SRC + 1] = vt[v].hi;
            run(0, 1);
            chk("vec_byte30", int'(mem[30]), int'(vt[v].e30));
            chk("vec_byte31", int'(mem[31]), int'(vt[v].e31));
        end

        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("done_held", int'(s_done), 1);
            chk("done_not_busy", int'(s_busy), 0);
        end

        // Random run with a stray start mid-run, then a restart from DONE.
        fill();
        run(10, 1);
        run(0, 1);
        // Start held for several cycles launches one run only.
        fill();
        run(0, 4);

        // Reset at cycle 25 of a run aborts it.
        fill();
        push_run();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 1; n < 25; n++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("abort_busy", int'(s_busy), 0);
        chk("abort_done", int'(s_done), 0);
        chk("abort_addr", int'(s_addr), 0);
        chk("abort_we", int'(s_we), 0);
        chk("abort_sb_left", sb_q.size(), 18);
        sb_q.delete();
        for (int n = 0; n < 10; n++) cyc();
        for (int k = DST + 12; k < DST + 2 * NMSG; k++) chk("abort_untouched", int'(mem[k]), 8'hA5);
        for (int k = DST; k < DST + 12; k++) chk("abort_written", int'(mem[k]), int'(exp_dst[k]));
        fill();
        run(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_enc_seq.md
HAMMING_ENC_SEQ -- requirements
Module: hamming_enc_seq

Interface
REQ-001 The block SHALL have parameter NUM_MSG, default 15, giving the number of messages encoded per run.
REQ-002 The block SHALL have parameter SRC_BASE, default 0, giving the data-memory byte address of message 0.
REQ-003 The block SHALL have parameter DST_BASE, default 30, giving the data-memory byte address of encoded word 0.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1, a one-cycle run request.
REQ-007 The block SHALL have port mem_rd_data, input, 8, the byte at mem_addr, read combinationally from data memory.
REQ-008 The block SHALL have port mem_addr, output, 8, the data-memory byte address.
REQ-009 The block SHALL have port mem_wr_en, output, 1, the write strobe; memory writes mem_wr_data at the clock edge.
REQ-010 The block SHALL have port mem_wr_data, output, 8, the write byte.
REQ-011 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 The block SHALL have port done, output, 1, the run-complete flag.

Function
REQ-013 The FSM SHALL use the states IDLE, RD_LO, RD_HI, WR_LO, WR_HI and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL clear the message index i to 0, clear done and go to RD_LO the next cycle.
REQ-015 In RD_LO, mem_addr SHALL be SRC_BASE+2i, and the block SHALL capture mem_rd_data as d[8:1].
REQ-016 In RD_HI, mem_addr SHALL be SRC_BASE+2i+1, and the block SHALL capture mem_rd_data[2:0] as d[11:9] and ignore bits [7:3].
REQ-017 The 16-bit code word SHALL be {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}, where:
- p8 = ^d[11:5]
- p4 = ^d[11:8] ^ ^d[4:2]
- p2 = d11^d10^d7^d6^d4^d3^d1
- p1 = d11^d9^d7^d5^d4^d2^d1
- p0 = ^d ^ p8 ^ p4 ^ p2 ^ p1
REQ-018 In WR_LO, mem_addr SHALL be DST_BASE+2i, mem_wr_data SHALL be code[7:0] and mem_wr_en SHALL be 1.
REQ-019 In WR_HI, mem_addr SHALL be DST_BASE+2i+1, mem_wr_data SHALL be code[15:8] and mem_wr_en SHALL be 1.
REQ-020 From WR_HI, the next state SHALL be RD_LO with i+1 when i < NUM_MSG-1, and DONE otherwise.
REQ-021 Each message SHALL take exactly 4 cycles, so a run takes 4*NUM_MSG cycles (60 at default) from leaving IDLE to entering DONE.
REQ-022 mem_wr_en SHALL be 1 only in WR_LO and WR_HI, with exactly 2*NUM_MSG writes per run.
REQ-023 busy SHALL be 1 exactly in RD_LO, RD_HI, WR_LO and WR_HI.
REQ-024 done SHALL be 1 in DONE and held until the next start or reset.
REQ-025 start asserted while busy=1 SHALL be ignored.
REQ-026 start held high across several cycles SHALL begin only one run, and a new run SHALL start only from IDLE or DONE.
REQ-027 Index i and all address arithmetic SHALL be 8-bit unsigned; parameters SHALL satisfy DST_BASE+2*NUM_MSG <= 256, with no wrap required.
REQ-028 In IDLE and DONE, mem_addr SHALL be 0 and mem_wr_data SHALL be 0.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL enter IDLE with i=0, busy=0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0 and captured data 0.
REQ-030 Reset SHALL take priority over start, and reset during a run SHALL abort it with no further writes; bytes already written SHALL stay as written.

Structure
REQ-031 Package hamming_pkg SHALL hold the state enum type, the default NUM_MSG/SRC_BASE/DST_BASE constants and the code-word bit-position constants.
REQ-032 The parity logic SHALL be a combinational sub-module hamming_enc with an 11-bit input d and a 16-bit output code, shared with any later decoder bench.

Verification
REQ-033 Message 0 bytes {hi=0x00, lo=0x00} SHALL encode to byte 30 = 0x00 and byte 31 = 0x00.
REQ-034 Message 0 = {0x07, 0xFF} (d=0x7FF) SHALL encode to byte 30 = 0xFF and byte 31 = 0xFF; and {0x00, 0x01} SHALL encode to byte 30 = 0x0F and byte 31 = 0x00.
REQ-035 Message 0 = {0x04, 0x00} (d11 only) SHALL encode to byte 30 = 0x17 and byte 31 = 0x81; and {0xF8, 0x00} SHALL encode to 0x0000, proving bits [7:3] are ignored.
REQ-036 A full 15-message run with random d SHALL match the REQ-017 reference model at bytes 30..59, busy SHALL last 60 cycles, and bytes 0..29 SHALL be unchanged.
REQ-037 start pulsed at cycle 10 of a run SHALL leave the run length and results unchanged, and start in DONE SHALL clear done and repeat the run.
REQ-038 reset asserted at cycle 25 of a run SHALL give IDLE the next cycle with no writes afterward, and a following start SHALL complete correctly.
